// File: rtl/apb_manager.sv
// rtl/apb_manager.sv - APB manager: single-outstanding host request/response port to an APB bus
// Peripheral index is taken from a field of the request address; out-of-range indices are errored locally.
module apb_manager #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int ProtWidth     = 4,
    parameter int PrphNum       = 4,
    parameter int PrphSelLsb    = 12,
    parameter int TimeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic [AddrWidth-1:0] reqAddr,
    input  logic                 reqWrite,
    input  logic [DataWidth-1:0] reqWData,
    input  logic [ProtWidth-1:0] reqProt,
    output logic                 rspValid,
    input  logic                 rspReady,
    output logic [DataWidth-1:0] rspRData,
    output logic                 rspErr,
    output logic [PrphNum-1:0]   selectors,
    output logic [AddrWidth-1:0] addr,
    output logic                 write,
    output logic [ProtWidth-1:0] prot,
    output logic [DataWidth-1:0] wData,
    output logic                 sel,
    output logic                 enable,
    input  logic                 ready,
    input  logic [DataWidth-1:0] rData,
    input  logic                 subErr
);

    // Index field is wide enough to hold PrphNum itself, so indices just past the last peripheral are seen
    localparam int IdxWidth = $clog2(PrphNum + 1);
    localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
    localparam bit TimeoutEn = (TimeoutCycles > 0);
    localparam logic [CntWidth-1:0] CntLast = TimeoutEn ? CntWidth'(TimeoutCycles - 1) : '0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]          state;
    logic [CntWidth-1:0] wait_cnt;
    logic [PrphNum-1:0]  sel_onehot;
    logic [IdxWidth-1:0] req_idx;
    logic                in_range;

    assign req_idx  = reqAddr[PrphSelLsb +: IdxWidth];
    assign in_range = (32'(req_idx) < 32'(PrphNum));

    assign reqReady  = (state == IDLE);
    assign sel       = (state == SETUP) || (state == ACCESS);
    assign enable    = (state == ACCESS);
    assign rspValid  = (state == RESP);
    assign selectors = sel ? sel_onehot : '0;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            sel_onehot <= '0;
            addr       <= '0;
            write      <= 1'b0;
            prot       <= '0;
            wData      <= '0;
            rspRData   <= '0;
            rspErr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        if (in_range) begin
                            state      <= SETUP;
                            wait_cnt   <= '0;
                            sel_onehot <= PrphNum'(1) << req_idx;
                            addr       <= reqAddr;
                            write      <= reqWrite;
                            prot       <= reqProt;
                            wData      <= reqWData;
                        end else begin
                            // Decode error: answered locally, APB outputs keep their last values
                            state    <= RESP;
                            rspErr   <= 1'b1;
                            rspRData <= '0;
                        end
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (ready) begin
                        state    <= RESP;
                        rspErr   <= subErr;
                        rspRData <= write ? '0 : rData;
                    end else if (TimeoutEn && (wait_cnt == CntLast)) begin
                        state    <= RESP;
                        rspErr   <= 1'b1;
                        rspRData <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CntWidth'(1);
                    end
                end
                RESP: begin
                    if (rspReady) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_manager.sv
// tb/tb_apb_manager.sv - randomized self-checking bench for apb_manager against a transaction-level model
module tb_apb_manager;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int PW   = 4;
    localparam int PN   = 4;
    localparam int LSB  = 12;
    localparam int TO   = 16;
    localparam int IDXB = 3;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic [AW-1:0] reqAddr = '0;
    logic          reqWrite = 1'b0;
    logic [DW-1:0] reqWData = '0;
    logic [PW-1:0] reqProt = '0;
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic [DW-1:0] rspRData;
    logic          rspErr;
    logic [PN-1:0] selectors;
    logic [AW-1:0] addr;
    logic          write;
    logic [PW-1:0] prot;
    logic [DW-1:0] wData;
    logic          sel;
    logic          enable;
    logic          ready = 1'b0;
    logic [DW-1:0] rData = '0;
    logic          subErr = 1'b0;

    always #5 clk = ~clk;

    apb_manager #(
        .AddrWidth(AW), .DataWidth(DW), .ProtWidth(PW), .PrphNum(PN),
        .PrphSelLsb(LSB), .TimeoutCycles(TO)
    ) dut (
        .clk(clk), .nReset(nReset),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqWrite(reqWrite),
        .reqWData(reqWData), .reqProt(reqProt),
        .rspValid(rspValid), .rspReady(rspReady), .rspRData(rspRData), .rspErr(rspErr),
        .selectors(selectors), .addr(addr), .write(write), .prot(prot), .wData(wData),
        .sel(sel), .enable(enable), .ready(ready), .rData(rData), .subErr(subErr)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle, set by the driver from the transaction plan
    logic          e_reqReady, e_rspValid, e_sel, e_enable, e_rspErr;
    logic [PN-1:0] e_selectors;
    logic [DW-1:0] e_rspRData;
    logic [AW-1:0] last_addr = '0;
    logic          last_write = 1'b0;
    logic [PW-1:0] last_prot = '0;
    logic [DW-1:0] last_wd = '0;

    int            cyc = 0, en_total = 0, sel_total = 0, rv_rise = 0;
    logic          rv_prev = 1'b0;
    logic [PN-1:0] sel_seen = '0;
    logic [DW-1:0] cap_data = '0;
    logic          cap_err = 1'b0;
    int            hs_cyc, en0, sel0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("reqReady", reqReady, e_reqReady);
            chk("rspValid", rspValid, e_rspValid);
            chk("sel", sel, e_sel);
            chk("enable", enable, e_enable);
            chk("selectors", selectors, e_selectors);
            chk("addr", addr, last_addr);
            chk("write", write, last_write);
            chk("prot", prot, last_prot);
            chk("wData", wData, last_wd);
            if (e_rspValid) begin
                chk("rspRData", rspRData, e_rspRData);
                chk("rspErr", rspErr, e_rspErr);
            end
        end
        cyc++;
        if (enable) en_total++;
        if (sel) sel_total++;
        if (selectors != '0) sel_seen = selectors;
        if (rspValid && !rv_prev) begin
            rv_rise  = cyc;
            cap_data = rspRData;
            cap_err  = rspErr;
        end
        rv_prev = rspValid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        e_reqReady = 1'b1; e_rspValid = 1'b0; e_sel = 1'b0; e_enable = 1'b0;
        e_selectors = '0; e_rspRData = '0; e_rspErr = 1'b0;
    endtask

    task automatic junk_inputs();
        reqAddr = $urandom; reqWrite = 1'($urandom); reqWData = $urandom; reqProt = PW'($urandom);
        rData = $urandom; subErr = 1'($urandom);
    endtask

    // One host transaction; waits = ACCESS cycles with ready low before ready rises
    task automatic txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                       input logic [PW-1:0] p, input int waits, input logic [DW-1:0] rd,
                       input logic serr, input int rdelay, input int idle_pre);
        int            idx;
        logic [DW-1:0] x_data;
        logic          x_err;
        for (int i = 0; i < idle_pre; i++) begin
            exp_idle(); reqValid = 1'b0; junk_inputs(); ready = 1'($urandom); rspReady = 1'($urandom);
            step();
        end
        exp_idle();
        reqValid = 1'b1; reqAddr = a; reqWrite = w; reqWData = wd; reqProt = p;
        ready = 1'($urandom); rspReady = 1'($urandom);
        step();
        hs_cyc = cyc; en0 = en_total; sel0 = sel_total;
        reqValid = 1'($urandom); junk_inputs();
        idx = int'((a >> LSB) & ((1 << IDXB) - 1));
        x_data = '0;
        x_err  = 1'b1;
        if (idx < PN) begin
            last_addr = a; last_write = w; last_prot = p; last_wd = wd;
            e_reqReady = 1'b0; e_rspValid = 1'b0; e_sel = 1'b1; e_enable = 1'b0;
            e_selectors = PN'(1) << idx;
            ready = 1'($urandom);
            step();
            for (int k = 0; k < 1000; k++) begin
                e_enable = 1'b1;
                reqValid = 1'($urandom); reqAddr = $urandom;
                if (k == waits) begin
                    ready = 1'b1; rData = rd; subErr = serr;
                end else begin
                    ready = 1'b0; rData = $urandom; subErr = 1'($urandom);
                end
                step();
                if (k == waits) begin
                    x_err  = serr;
                    x_data = w ? '0 : rd;
                    break;
                end
                if (TO > 0 && k + 1 == TO) break;
            end
        end
        for (int j = 0; j <= rdelay; j++) begin
            e_reqReady = 1'b0; e_sel = 1'b0; e_enable = 1'b0; e_selectors = '0;
            e_rspValid = 1'b1; e_rspRData = x_data; e_rspErr = x_err;
            rspReady = (j == rdelay); ready = 1'($urandom); reqValid = 1'($urandom); junk_inputs();
            step();
        end
        exp_idle();
        reqValid = 1'b0; rspReady = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_idle();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nReset = 1'b1;

        // Write to peripheral 1, ready on first ACCESS
        txn(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'h5, 0, 32'h0, 1'b0, 0, 1);
        chk("r18_latency", rv_rise - hs_cyc, 3);
        chk("r18_access_cycles", en_total - en0, 1);
        chk("r18_selectors", sel_seen, 4'b0010);
        chk("r18_rdata", cap_data, 32'h0);
        chk("r18_err", cap_err, 1'b0);

        // Read from peripheral 3 with two wait states
        txn(32'h0000_3000, 1'b0, 32'h0, 4'h2, 2, 32'h1234_5678, 1'b0, 0, 1);
        chk("r19_selectors", sel_seen, 4'b1000);
        chk("r19_access_cycles", en_total - en0, 3);
        chk("r19_latency", rv_rise - hs_cyc, 5);
        chk("r19_rdata", cap_data, 32'h1234_5678);
        chk("r19_err", cap_err, 1'b0);

        // Index 5 is beyond the peripheral count
        txn(32'h0000_5000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0, 1);
        chk("r20_sel_cycles", sel_total - sel0, 0);
        chk("r20_latency", rv_rise - hs_cyc, 1);
        chk("r20_err", cap_err, 1'b1);
        chk("r20_rdata", cap_data, 32'h0);

        // Peripheral never ready
        txn(32'h0000_2010, 1'b0, 32'h0, 4'h1, 100, 32'hFFFF_FFFF, 1'b0, 0, 1);
        chk("r21_access_cycles", en_total - en0, 16);
        chk("r21_err", cap_err, 1'b1);
        chk("r21_rdata", cap_data, 32'h0);

        // Peripheral error on read, host stalls the response
        txn(32'h0000_2008, 1'b0, 32'h0, 4'h3, 0, 32'hCAFE_F00D, 1'b1, 5, 0);
        chk("r22_err", cap_err, 1'b1);
        chk("r22_rdata", cap_data, 32'hCAFE_F00D);

        // Randomized traffic, back-to-back and with idle gaps
        for (int t = 0; t < 150; t++) begin
            logic [AW-1:0] a;
            int            waits;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[LSB+2] = 1'b0;
            waits = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4);
            txn(a, 1'($urandom), $urandom, PW'($urandom), waits, $urandom, 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset pulse in the middle of ACCESS
        exp_idle();
        reqValid = 1'b1; reqAddr = 32'h0000_2000; reqWrite = 1'b0; reqWData = 32'h0; reqProt = 4'h0;
        step();
        last_addr = 32'h0000_2000; last_write = 1'b0; last_prot = 4'h0; last_wd = 32'h0;
        reqValid = 1'b0;
        e_reqReady = 1'b0; e_sel = 1'b1; e_enable = 1'b0; e_selectors = 4'b0100;
        step();
        e_enable = 1'b1; ready = 1'b0;
        step();
        chk_en = 1'b0;
        #2;
        nReset = 1'b0;
        #1;
        chk("r23_sel", sel, 1'b0);
        chk("r23_enable", enable, 1'b0);
        chk("r23_selectors", selectors, 4'b0000);
        chk("r23_reqReady_in_reset", reqReady, 1'b1);
        step();
        step();
        nReset = 1'b1;
        last_addr = '0; last_write = 1'b0; last_prot = '0; last_wd = '0;
        exp_idle();
        #1;
        chk("r23_reqReady", reqReady, 1'b1);
        chk("r23_rspValid", rspValid, 1'b0);
        chk_en = 1'b1;
        step();
        step();

        // Traffic still works after the abandoned transfer
        txn(32'h0000_0040, 1'b0, 32'h0, 4'h7, 1, 32'h0BAD_F00D, 1'b0, 1, 0);
        chk("post_reset_rdata", cap_data, 32'h0BAD_F00D);
        chk("post_reset_selectors", sel_seen, 4'b0001);
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
